// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger game-state logic.
//   state_e    : round state machine encoding (3 bits)
//   X_W / Y_W  : screen coordinate widths for x and y edges
//   GOAL_Y_DEF, LIVES_INIT_DEF, LEVEL_MAX_DEF : default game constants
package frogger_pkg;

   localparam int X_W = 10;
   localparam int Y_W = 9;

   localparam logic [Y_W-1:0] GOAL_Y_DEF     = 9'd40;
   localparam logic [1:0]     LIVES_INIT_DEF = 2'd3;
   localparam logic [2:0]     LEVEL_MAX_DEF  = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PLAY    = 3'd1,
      ST_HIT     = 3'd2,
      ST_LEVELUP = 3'd3,
      ST_OVER    = 3'd4
   } state_e;

endpackage

// File: rtl/collision_ctrl_box_overlap.sv
// Combinational rectangle-intersect test between two 4-edge boxes.
// Strict inequalities: boxes whose edges only touch do not overlap.
//   a_l/a_r, b_l/b_r : x edges (X_W bits)
//   a_t/a_b, b_t/b_b : y edges (Y_W bits)
//   overlap          : 1 when the interiors intersect
module box_overlap
   import frogger_pkg::*;
(
   input  logic [X_W-1:0] a_l,
   input  logic [X_W-1:0] a_r,
   input  logic [Y_W-1:0] a_t,
   input  logic [Y_W-1:0] a_b,
   input  logic [X_W-1:0] b_l,
   input  logic [X_W-1:0] b_r,
   input  logic [Y_W-1:0] b_t,
   input  logic [Y_W-1:0] b_b,
   output logic           overlap
);

   assign overlap = (a_l < b_r) & (a_r > b_l) & (a_t < b_b) & (a_b > b_t);

endmodule

// File: rtl/collision_ctrl.sv
// Round controller: compares the frog box against the car box, tracks
// lives and level, and drives the car run-enable and frog respawn pulse.
//   clk_in, reset_in (sync, active-low), start (level, synchronised)
//   carL/carR/carT/carB, frogL/frogR/frogT/frogB : bounding boxes
//   pseudo    : car run-enable, high only in PLAY
//   frog_rst  : one-cycle respawn pulse
//   hit       : one-cycle pulse per collision
//   lives, level, game_over : game status
//
// state   | meaning
// IDLE    | waiting for start after reset
// PLAY    | car running, watching for collision or goal
// HIT     | frozen after a collision, counting down
// LEVELUP | frozen after reaching the goal, counting down
// OVER    | no lives left, waiting for start
module collision_ctrl
   import frogger_pkg::*;
#(
   parameter logic [1:0]     LIVES_INIT    = LIVES_INIT_DEF,
   parameter logic [2:0]     LEVEL_MAX     = LEVEL_MAX_DEF,
   parameter logic [Y_W-1:0] GOAL_Y        = GOAL_Y_DEF,
   parameter logic [27:0]    FREEZE_CYCLES = 28'd50000000
)(
   input  logic           clk_in,
   input  logic           reset_in,
   input  logic           start,
   input  logic [X_W-1:0] carL,
   input  logic [X_W-1:0] carR,
   input  logic [Y_W-1:0] carT,
   input  logic [Y_W-1:0] carB,
   input  logic [X_W-1:0] frogL,
   input  logic [X_W-1:0] frogR,
   input  logic [Y_W-1:0] frogT,
   input  logic [Y_W-1:0] frogB,
   output logic           pseudo,
   output logic           frog_rst,
   output logic           hit,
   output logic [1:0]     lives,
   output logic [2:0]     level,
   output logic           game_over
);

   state_e      state_q, state_d;
   logic        overlap_c, overlap_q, goal_q;
   logic [27:0] freeze_cnt, freeze_cnt_d;
   logic [1:0]  lives_d;
   logic [2:0]  level_d;
   logic        hit_d, frog_rst_d;

   box_overlap u_box_overlap (
      .a_l     (frogL),
      .a_r     (frogR),
      .a_t     (frogT),
      .a_b     (frogB),
      .b_l     (carL),
      .b_r     (carR),
      .b_t     (carT),
      .b_b     (carB),
      .overlap (overlap_c)
   );

   always_comb begin
      state_d      = state_q;
      lives_d      = lives;
      level_d      = level;
      freeze_cnt_d = freeze_cnt;
      hit_d        = 1'b0;
      frog_rst_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_PLAY;
               frog_rst_d = 1'b1;
            end
         end
         ST_PLAY: begin
            // collision takes priority over the goal
            if (overlap_q) begin
               hit_d = 1'b1;
               if (lives <= 2'd1) begin
                  lives_d = 2'd0;
                  state_d = ST_OVER;
               end else begin
                  lives_d      = lives - 2'd1;
                  state_d      = ST_HIT;
                  freeze_cnt_d = FREEZE_CYCLES - 28'd1;
               end
            end else if (goal_q) begin
               if (level < LEVEL_MAX) level_d = level + 3'd1;
               state_d      = ST_LEVELUP;
               freeze_cnt_d = FREEZE_CYCLES - 28'd1;
            end
         end
         ST_HIT, ST_LEVELUP: begin
            if (freeze_cnt == 28'd0) begin
               state_d    = ST_PLAY;
               frog_rst_d = 1'b1;
            end else begin
               freeze_cnt_d = freeze_cnt - 28'd1;
            end
         end
         ST_OVER: begin
            if (start) begin
               lives_d    = LIVES_INIT;
               level_d    = 3'd0;
               state_d    = ST_PLAY;
               frog_rst_d = 1'b1;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            freeze_cnt_d = 28'd0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         state_q    <= ST_IDLE;
         lives      <= LIVES_INIT;
         level      <= 3'd0;
         freeze_cnt <= 28'd0;
         overlap_q  <= 1'b0;
         goal_q     <= 1'b0;
         pseudo     <= 1'b0;
         frog_rst   <= 1'b0;
         hit        <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lives      <= lives_d;
         level      <= level_d;
         freeze_cnt <= freeze_cnt_d;
         overlap_q  <= overlap_c;
         goal_q     <= (frogT <= GOAL_Y);
         pseudo     <= (state_d == ST_PLAY);
         frog_rst   <= frog_rst_d;
         hit        <= hit_d;
         game_over  <= (state_d == ST_OVER);
      end
   end

endmodule

// File: tb/tb_collision_ctrl.sv
module tb_collision_ctrl;

   logic       clk_in = 1'b0;
   logic       reset_in, start;
   logic [9:0] carL, carR, frogL, frogR;
   logic [8:0] carT, carB, frogT, frogB;
   logic       pseudo, frog_rst, hit, game_over;
   logic [1:0] lives;
   logic [2:0] level;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   collision_ctrl #(.FREEZE_CYCLES(28'd4)) dut (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .start     (start),
      .carL      (carL),
      .carR      (carR),
      .carT      (carT),
      .carB      (carB),
      .frogL     (frogL),
      .frogR     (frogR),
      .frogT     (frogT),
      .frogB     (frogB),
      .pseudo    (pseudo),
      .frog_rst  (frog_rst),
      .hit       (hit),
      .lives     (lives),
      .level     (level),
      .game_over (game_over)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // advance one rising edge; inputs are driven and outputs sampled at negedge
   task automatic tick();
      @(negedge clk_in);
   endtask

   task automatic set_frog(input int l, input int r, input int t, input int b);
      frogL = 10'(l); frogR = 10'(r); frogT = 9'(t); frogB = 9'(b);
   endtask

   task automatic park_frog();
      set_frog(500, 520, 300, 320);
   endtask

   // apply a box, then follow a 4-cycle freeze back into PLAY
   task automatic freeze_round(input string tag, input int l, input int r, input int t,
                               input int b, input int exp_hit, input int exp_lives,
                               input int exp_level);
      set_frog(l, r, t, b);
      tick();
      chk({tag, "_lat_hit"}, hit, 0);
      chk({tag, "_lat_pseudo"}, pseudo, 1);
      tick();
      chk({tag, "_hit"}, hit, exp_hit);
      chk({tag, "_lives"}, lives, exp_lives);
      chk({tag, "_level"}, level, exp_level);
      chk({tag, "_pseudo0"}, pseudo, 0);
      park_frog();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk({tag, "_frz_pseudo"}, pseudo, 0);
         chk({tag, "_frz_hit"}, hit, 0);
      end
      tick();
      chk({tag, "_exit_pseudo"}, pseudo, 1);
      chk({tag, "_exit_frog_rst"}, frog_rst, 1);
      tick();
      chk({tag, "_post_frog_rst"}, frog_rst, 0);
      chk({tag, "_post_pseudo"}, pseudo, 1);
   endtask

   initial begin
      reset_in = 1'b0;
      start    = 1'b0;
      carL = 10'd20; carR = 10'd80; carT = 9'd110; carB = 9'd150;
      park_frog();
      tick();
      tick();
      reset_in = 1'b1;
      tick();
      chk("rst_lives", lives, 3);
      chk("rst_level", level, 0);
      chk("rst_pseudo", pseudo, 0);
      chk("rst_frog_rst", frog_rst, 0);
      chk("rst_hit", hit, 0);
      chk("rst_game_over", game_over, 0);
      tick();
      chk("idle_pseudo", pseudo, 0);

      start = 1'b1;
      tick();
      chk("start_pseudo", pseudo, 1);
      chk("start_frog_rst", frog_rst, 1);
      start = 1'b0;
      tick();
      chk("start_frog_rst_1cyc", frog_rst, 0);
      chk("start_pseudo_hold", pseudo, 1);

      freeze_round("hit1", 40, 60, 120, 140, 1, 2, 0);

      // touching edge: frogL == carR
      set_frog(80, 100, 120, 140);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("touch_hit", hit, 0);
         chk("touch_pseudo", pseudo, 1);
      end
      chk("touch_lives", lives, 2);
      park_frog();
      tick();

      freeze_round("goal1", 500, 520, 40, 60, 0, 2, 1);
      freeze_round("goal2", 500, 520, 40, 60, 0, 2, 2);
      freeze_round("goal3", 500, 520, 40, 60, 0, 2, 2);

      // goal and overlap together: hit wins, level unchanged
      freeze_round("both", 40, 60, 40, 140, 1, 1, 2);

      // last life -> OVER
      set_frog(40, 60, 120, 140);
      tick();
      tick();
      chk("over_hit", hit, 1);
      chk("over_lives", lives, 0);
      chk("over_game_over", game_over, 1);
      chk("over_pseudo", pseudo, 0);
      park_frog();
      tick();
      chk("over_hit_1cyc", hit, 0);
      chk("over_hold", game_over, 1);
      chk("over_lives_hold", lives, 0);

      start = 1'b1;
      tick();
      chk("restart_lives", lives, 3);
      chk("restart_level", level, 0);
      chk("restart_game_over", game_over, 0);
      chk("restart_pseudo", pseudo, 1);
      chk("restart_frog_rst", frog_rst, 1);
      tick();
      chk("start_held_frog_rst", frog_rst, 0);
      chk("start_held_pseudo", pseudo, 1);
      start = 1'b0;

      freeze_round("g2_hit1", 40, 60, 120, 140, 1, 2, 0);
      freeze_round("g2_hit2", 40, 60, 120, 140, 1, 1, 0);
      set_frog(40, 60, 120, 140);
      tick();
      tick();
      chk("g2_over_lives", lives, 0);
      chk("g2_over_game_over", game_over, 1);
      park_frog();
      tick();

      start = 1'b1;
      tick();
      chk("g3_pseudo", pseudo, 1);
      start = 1'b0;
      freeze_round("g3_goal", 500, 520, 40, 60, 0, 3, 1);

      // reset in the middle of a freeze
      set_frog(40, 60, 120, 140);
      tick();
      tick();
      chk("midrst_hit", hit, 1);
      chk("midrst_lives_pre", lives, 2);
      park_frog();
      tick();
      reset_in = 1'b0;
      tick();
      chk("midrst_cnt", int'(dut.freeze_cnt), 0);
      chk("midrst_lives", lives, 3);
      chk("midrst_level", level, 0);
      chk("midrst_pseudo", pseudo, 0);
      chk("midrst_frog_rst", frog_rst, 0);
      reset_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("midrst_idle_pseudo", pseudo, 0);
         chk("midrst_idle_frog_rst", frog_rst, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/collision_ctrl.md
Name: collision_ctrl

Overview:
- Game-state controller directly downstream of the car mover: consumes the car bounding box, compares it against the frog bounding box, and runs the round state machine.
- Drives the car's run-enable (`pseudo`) and the frog respawn pulse.
- Tracks lives and level; the level output feeds back to the car's speed select.
- Single clock domain on the board clock; bounding-box inputs are treated as quasi-static (they change on slow divided clocks).

Parameters:
- `LIVES_INIT`, 3, lives loaded at reset and at game restart (1..3).
- `LEVEL_MAX`, 2, saturation value of level.
- `GOAL_Y`, 9'd40, frog reaches goal when `frogT <= GOAL_Y`.
- `FREEZE_CYCLES`, 28'd50000000, length of the HIT and LEVELUP pause in clk_in cycles (>= 2).

Ports:
- `clk_in`  input  1  board clock.
- `reset_in`  input  1  reset, synchronous and active-low (as decided).
- `start`  input  1  level-sensitive start/restart button, already synchronised.
- `carL`, `carR`  input  10  car left/right x edges.
- `carT`, `carB`  input  9  car top/bottom y edges.
- `frogL`, `frogR`  input  10  frog left/right x edges.
- `frogT`, `frogB`  input  9  frog top/bottom y edges.
- `pseudo`  output  1  car run-enable; 1 only in PLAY.
- `frog_rst`  output  1  one-cycle respawn pulse to the frog mover.
- `hit`  output  1  one-cycle pulse on each collision.
- `lives`  output  2  remaining lives.
- `level`  output  3  current level, 0..`LEVEL_MAX`.
- `game_over`  output  1  high in OVER.

Behaviour:
- All registers update on posedge `clk_in`. `reset_in==0` on an edge forces reset regardless of state, including mid-freeze.
- Reset values:
  - state IDLE; `lives=LIVES_INIT`; `level=0`.
  - `pseudo`, `frog_rst`, `hit`, `game_over` = 0.
  - `overlap_q=0`; freeze counter 0.
- Overlap (combinational, all unsigned, strict inequalities):
  - `(frogL<carR) & (frogR>carL) & (frogT<carB) & (frogB>carT)`.
  - Edges that merely touch are not a hit.
  - The result is registered into `overlap_q`, giving 1 cycle of latency from the inputs.
- Goal condition: `goal_q` is registered in the same way from `frogT<=GOAL_Y`.
- States:
  - IDLE:
    - `pseudo=0`.
    - `start=1` -> PLAY, with `frog_rst=1` for that transition cycle.
  - PLAY:
    - `pseudo=1`; `start` is ignored.
    - `overlap_q=1` -> HIT. Decrement lives, `hit=1` for one cycle, load the counter with `FREEZE_CYCLES-1`.
    - If lives was 1, go to OVER instead of HIT: lives becomes 0, `hit` still pulses.
    - Else if `goal_q=1` -> LEVELUP: `level = min(level+1, LEVEL_MAX)`, load the counter.
    - Overlap and goal in the same cycle: the hit wins.
  - HIT / LEVELUP:
    - `pseudo=0`, so the car returns to its home position.
    - Counter decrements each cycle. At 0 -> PLAY, with `frog_rst=1` on the exit cycle.
    - Overlap and goal are ignored.
  - OVER:
    - `game_over=1`; `pseudo=0`.
    - `start=1` -> reload `lives=LIVES_INIT`, `level=0`, `game_over=0` -> PLAY, with `frog_rst` pulse.
- Timing guarantees:
  - `frog_rst` and `hit` are never high for more than one consecutive cycle.
  - `lives` never underflows.
  - `level` saturates and does not wrap.
- Counter: width sized for `FREEZE_CYCLES` (28 bits at default); it holds at 0 outside HIT/LEVELUP.
- `start` held high continuously: restart occurs only from IDLE or OVER. No auto-repeat from PLAY.

Decomposition:
- Package `frogger_pkg`:
  - state enum (IDLE, PLAY, HIT, LEVELUP, OVER), 3-bit encoding;
  - screen constants: `GOAL_Y` default, `LIVES_INIT`, `LEVEL_MAX`, box widths 10/9.
- Sub-module `box_overlap`: purely combinational rectangle-intersect test (two 4-edge boxes in, 1 bit out). Reusable for additional car lanes.

Test Plan (`FREEZE_CYCLES=4`):
- Reset low 2 cycles, then high with `start=0` -> IDLE, `lives=3`, `level=0`, `pseudo=0`, all pulses 0.
- `start=1` one cycle -> next edge: `pseudo=1`, `frog_rst` high for exactly 1 cycle.
- In PLAY:
  - Stimulus: frog box 40..60 x 120..140; car box 20..80 x 110..150.
  - Required response: `hit` pulse 2 edges after the box is applied; `lives=2`; `pseudo=0` for 4 cycles; then PLAY with a `frog_rst` pulse.
- Touching edges, `frogL=80` with `carR=80` -> no hit; `lives` unchanged.
- Frog with `frogT=40` (no overlap) -> `level` 0->1 and a pause of 4 cycles.
  - Repeating the goal 3 times -> `level` stops at 2.
  - Goal and overlap applied together -> `hit` is taken and `level` is unchanged.
- Three hits from `lives=3`:
  - Required response: OVER with `game_over=1` and `lives=0`.
  - `start` -> `lives=3`, `level=0`, PLAY.
  - Reset asserted mid-freeze -> IDLE on the next edge, with the counter at 0.
